wbu_csr_commit: RTL and testbench

Write-back stage for CSR instructions, downstream of the EXU CSR unit. It queues completed CSR results in a small FIFO and drains each entry atomically: the CSR-file write and the GPR write of the same instruction land in the same cycle. It shares the single GPR write port with the ALU path, and the ALU always has priority. It also reports pending CSR writes so decode can stall CSR reads that would hit in-flight data.

---
 rtl/alioth_wb_pkg.sv | 22 ++
 rtl/wbu_csr_fifo.sv | 65 ++++++
 rtl/wbu_csr_commit.sv | 105 ++++++++++
 tb/tb_wbu_csr_commit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alioth_wb_pkg.sv
// Shared write-back types: bus/register widths and the queued CSR result entry.
package alioth_wb_pkg;

    localparam int BUS_ADDR_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      csr_we;
        logic [BUS_ADDR_WIDTH-1:0] csr_waddr;
        logic [REG_DATA_WIDTH-1:0] csr_wdata;
        logic                      reg_we;
        logic [REG_ADDR_WIDTH-1:0] reg_waddr;
        logic [REG_DATA_WIDTH-1:0] reg_wdata;
    } csr_wb_entry_t;

    // x0 is hardwired to zero, so a write there must never strobe the GPR port.
    function automatic logic gpr_commit(input logic we, input logic [REG_ADDR_WIDTH-1:0] addr);
        return we && (addr != '0);
    endfunction

endpackage

// File: rtl/wbu_csr_fifo.sv
// Synchronous FIFO of CSR write-back entries; exposes every slot plus a per-slot
// valid vector so the parent can compare all in-flight CSR addresses.
module wbu_csr_fifo
    import alioth_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  csr_wb_entry_t wdata,
    output logic          full,
    output logic          empty,
    output csr_wb_entry_t head,
    output csr_wb_entry_t entries [DEPTH],
    output logic [DEPTH-1:0] valid
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW:0]   count;
    csr_wb_entry_t mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; the valid vector masks stale slots.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    assign head    = mem[rptr];
    assign entries = mem;

    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = ({1'b0, AW'(unsigned'(i)) - rptr} < count);
        end
    end

endmodule

// File: rtl/wbu_csr_commit.sv
// CSR write-back: queues CSR results and drains each one atomically onto the
// GPR and CSR write ports, yielding the shared GPR port to the ALU.
module wbu_csr_commit
    import alioth_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      csr_valid_i,
    input  logic                      csr_we_i,
    input  logic [BUS_ADDR_WIDTH-1:0] csr_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] csr_wdata_i,
    input  logic                      reg_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] reg_wdata_i,
    output logic                      csr_ready_o,
    input  logic                      alu_reg_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] alu_reg_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] alu_reg_wdata_i,
    input  logic [BUS_ADDR_WIDTH-1:0] csr_raddr_i,
    output logic                      csr_raw_hit_o,
    output logic                      csr_busy_o,
    output logic                      reg_we_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o,
    output logic [REG_DATA_WIDTH-1:0] reg_wdata_o,
    output logic                      csr_we_o,
    output logic [BUS_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [REG_DATA_WIDTH-1:0] csr_wdata_o
);

    csr_wb_entry_t    in_entry;
    csr_wb_entry_t    head;
    csr_wb_entry_t    entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             full;
    logic             empty;
    logic             pop;

    assign in_entry = '{csr_we:    csr_we_i,
                        csr_waddr: csr_waddr_i,
                        csr_wdata: csr_wdata_i,
                        reg_we:    reg_we_i,
                        reg_waddr: reg_waddr_i,
                        reg_wdata: reg_wdata_i};

    wbu_csr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (csr_valid_i),
        .pop     (pop),
        .wdata   (in_entry),
        .full    (full),
        .empty   (empty),
        .head    (head),
        .entries (entries),
        .valid   (valid)
    );

    // Ready comes from the count alone, so a full FIFO refuses a push even while popping.
    assign csr_ready_o = !full;
    assign csr_busy_o  = !empty;
    assign pop         = !empty && !(head.reg_we && alu_reg_we_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            csr_we_o    <= 1'b0;
            csr_waddr_o <= '0;
            csr_wdata_o <= '0;
        end else begin
            if (alu_reg_we_i) begin
                reg_we_o    <= gpr_commit(1'b1, alu_reg_waddr_i);
                reg_waddr_o <= alu_reg_waddr_i;
                reg_wdata_o <= alu_reg_wdata_i;
            end else if (pop) begin
                reg_we_o    <= gpr_commit(head.reg_we, head.reg_waddr);
                reg_waddr_o <= head.reg_waddr;
                reg_wdata_o <= head.reg_wdata;
            end else begin
                reg_we_o    <= 1'b0;
            end

            if (pop) begin
                csr_we_o    <= head.csr_we;
                csr_waddr_o <= head.csr_waddr;
                csr_wdata_o <= head.csr_wdata;
            end else begin
                csr_we_o    <= 1'b0;
            end
        end
    end

    // The committing write still counts as pending until the CSR file has absorbed it.
    always_comb begin
        csr_raw_hit_o = csr_we_o && (csr_waddr_o == csr_raddr_i);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i].csr_we && (entries[i].csr_waddr == csr_raddr_i))
                csr_raw_hit_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_wbu_csr_commit.sv
// Self-checking bench for wbu_csr_commit: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_wbu_csr_commit;
    import alioth_wb_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_valid_i, csr_we_i, reg_we_i, alu_reg_we_i;
    logic [31:0] csr_waddr_i, csr_wdata_i, reg_wdata_i, alu_reg_wdata_i, csr_raddr_i;
    logic [4:0]  reg_waddr_i, alu_reg_waddr_i;
    logic        csr_ready_o, csr_raw_hit_o, csr_busy_o, reg_we_o, csr_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o, csr_waddr_o, csr_wdata_o;

    always #5 clk = ~clk;

    wbu_csr_commit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_valid_i(csr_valid_i), .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i),
        .csr_wdata_i(csr_wdata_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
        .reg_wdata_i(reg_wdata_i), .csr_ready_o(csr_ready_o),
        .alu_reg_we_i(alu_reg_we_i), .alu_reg_waddr_i(alu_reg_waddr_i),
        .alu_reg_wdata_i(alu_reg_wdata_i), .csr_raddr_i(csr_raddr_i),
        .csr_raw_hit_o(csr_raw_hit_o), .csr_busy_o(csr_busy_o),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o)
    );

    // Reference model: queue of pending entries and the expected write ports.
    csr_wb_entry_t q[$];
    logic          m_reg_we, m_csr_we;
    logic [4:0]    m_reg_waddr;
    logic [31:0]   m_reg_wdata, m_csr_waddr, m_csr_wdata;
    bit            m_pushed;
    logic [31:0]   commits[$];
    int            n_assert = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic csr_wb_entry_t mk(input bit cwe, input logic [31:0] ca, input logic [31:0] cd,
                                         input bit rwe, input logic [4:0] ra, input logic [31:0] rd);
        csr_wb_entry_t e;
        e.csr_we = cwe; e.csr_waddr = ca; e.csr_wdata = cd;
        e.reg_we = rwe; e.reg_waddr = ra; e.reg_wdata = rd;
        return e;
    endfunction

    task automatic drive(input bit v, input csr_wb_entry_t e);
        csr_valid_i = v;
        csr_we_i = e.csr_we; csr_waddr_i = e.csr_waddr; csr_wdata_i = e.csr_wdata;
        reg_we_i = e.reg_we; reg_waddr_i = e.reg_waddr; reg_wdata_i = e.reg_wdata;
    endtask

    task automatic alu(input bit we, input logic [4:0] a, input logic [31:0] d);
        alu_reg_we_i = we; alu_reg_waddr_i = a; alu_reg_wdata_i = d;
    endtask

    function automatic bit exp_hit();
        bit h = (m_csr_we && m_csr_waddr == csr_raddr_i);
        foreach (q[i]) if (q[i].csr_we && q[i].csr_waddr == csr_raddr_i) h = 1'b1;
        return h;
    endfunction

    task automatic check_outputs();
        chk("reg_we", reg_we_o, m_reg_we);
        if (m_reg_we) begin
            chk("reg_waddr", reg_waddr_o, m_reg_waddr);
            chk("reg_wdata", reg_wdata_o, m_reg_wdata);
        end
        chk("csr_we", csr_we_o, m_csr_we);
        if (m_csr_we) begin
            chk("csr_waddr", csr_waddr_o, m_csr_waddr);
            chk("csr_wdata", csr_wdata_o, m_csr_wdata);
        end
        chk("ready", csr_ready_o, q.size() < DEPTH);
        chk("busy", csr_busy_o, q.size() != 0);
        chk("raw_hit", csr_raw_hit_o, exp_hit());
        if (csr_we_o === 1'b1) commits.push_back(csr_waddr_o);
    endtask

    // One clock: predict the edge from current inputs, clock it, then compare at negedge.
    task automatic step();
        csr_wb_entry_t e, h;
        bit            pop;
        e = mk(csr_we_i, csr_waddr_i, csr_wdata_i, reg_we_i, reg_waddr_i, reg_wdata_i);
        if (!rst_n) begin
            q.delete();
            m_reg_we = 0; m_reg_waddr = '0; m_reg_wdata = '0;
            m_csr_we = 0; m_csr_waddr = '0; m_csr_wdata = '0;
            m_pushed = 0;
        end else begin
            pop = (q.size() != 0) && !(q[0].reg_we && alu_reg_we_i);
            h = pop ? q[0] : '0;
            if (alu_reg_we_i) begin
                m_reg_we = (alu_reg_waddr_i != 0);
                m_reg_waddr = alu_reg_waddr_i; m_reg_wdata = alu_reg_wdata_i;
            end else if (pop) begin
                m_reg_we = h.reg_we && (h.reg_waddr != 0);
                m_reg_waddr = h.reg_waddr; m_reg_wdata = h.reg_wdata;
            end else begin
                m_reg_we = 0;
            end
            m_csr_we = pop ? h.csr_we : 1'b0;
            if (pop) begin
                m_csr_waddr = h.csr_waddr; m_csr_wdata = h.csr_wdata;
            end
            m_pushed = csr_valid_i && (q.size() < DEPTH);
            if (pop) void'(q.pop_front());
            if (m_pushed) q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        csr_wb_entry_t e1, e2, e3, r;
        bit accepted;
        rst_n = 1'b0;
        csr_raddr_i = 32'h305;
        drive(0, '0);
        alu(0, 0, 0);
        @(negedge clk);
        step();
        step();
        chk("rst_ready", csr_ready_o, 1);
        chk("rst_busy", csr_busy_o, 0);
        chk("rst_hit", csr_raw_hit_o, 0);
        chk("rst_reg_waddr", reg_waddr_o, 0);
        chk("rst_csr_waddr", csr_waddr_o, 0);
        rst_n = 1'b1;

        // Single CSRRW: both ports strobe two edges after the push, for one cycle.
        drive(1, mk(1, 32'h300, 32'h8, 1, 5, 32'h1800));
        step();
        drive(0, '0);
        step();
        chk("csrrw_reg_we", reg_we_o, 1);
        chk("csrrw_reg_waddr", reg_waddr_o, 5);
        chk("csrrw_reg_wdata", reg_wdata_o, 32'h1800);
        chk("csrrw_csr_we", csr_we_o, 1);
        chk("csrrw_csr_waddr", csr_waddr_o, 32'h300);
        chk("csrrw_csr_wdata", csr_wdata_o, 32'h8);
        step();
        chk("csrrw_once_reg", reg_we_o, 0);
        chk("csrrw_once_csr", csr_we_o, 0);

        // ALU holds the GPR port for 3 cycles; the CSR head then commits atomically.
        drive(1, mk(1, 32'h301, 32'h11, 1, 7, 32'h22));
        step();
        drive(0, '0);
        alu(1, 3, 32'hAA);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("conflict_alu_waddr", reg_waddr_o, 3);
            chk("conflict_alu_wdata", reg_wdata_o, 32'hAA);
            chk("conflict_csr_held", csr_we_o, 0);
        end
        alu(0, 0, 0);
        step();
        chk("conflict_reg_waddr", reg_waddr_o, 7);
        chk("conflict_reg_we", reg_we_o, 1);
        chk("conflict_csr_we", csr_we_o, 1);
        chk("conflict_csr_waddr", csr_waddr_o, 32'h301);
        step();

        // Fill with the ALU blocking, then drain in order.
        e1 = mk(1, 32'h310, 1, 1, 1, 32'h101);
        e2 = mk(1, 32'h311, 2, 1, 2, 32'h102);
        e3 = mk(1, 32'h312, 3, 1, 4, 32'h103);
        alu(1, 9, 32'h55);
        drive(1, e1); step();
        drive(1, e2); step();
        chk("full_ready_low", csr_ready_o, 0);
        drive(1, e3); step(); step();
        chk("full_still_busy", csr_busy_o, 1);
        commits.delete();
        alu(0, 0, 0);
        accepted = 0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            step();
            accepted = m_pushed;
        end
        chk("full_third_accepted", accepted, 1);
        drive(0, '0);
        for (int i = 0; i < 5; i++) step();
        chk("fill_commit_count", commits.size(), 3);
        if (commits.size() == 3) begin
            chk("fill_order0", commits[0], 32'h310);
            chk("fill_order1", commits[1], 32'h311);
            chk("fill_order2", commits[2], 32'h312);
        end

        // RAW hazard tracking through queue and output stages.
        csr_raddr_i = 32'h305;
        drive(1, mk(1, 32'h305, 1, 0, 0, 0));
        step();
        chk("haz_pending", csr_raw_hit_o, 1);
        drive(0, '0);
        step();
        chk("haz_output", csr_raw_hit_o, 1);
        step();
        chk("haz_cleared", csr_raw_hit_o, 0);
        csr_raddr_i = 32'h341;
        drive(1, mk(1, 32'h305, 1, 0, 0, 0));
        step();
        chk("haz_other_addr", csr_raw_hit_o, 0);
        drive(0, '0);
        step(); step();

        // x0 destination: CSR write only.
        drive(1, mk(1, 32'h340, 32'h5A, 1, 0, 32'h77));
        step();
        drive(0, '0);
        step();
        chk("x0_csr_we", csr_we_o, 1);
        chk("x0_reg_we", reg_we_o, 0);
        step();

        // Reset with two entries queued behind a busy ALU.
        alu(1, 6, 32'h66);
        drive(1, mk(1, 32'h320, 1, 1, 3, 1)); step();
        drive(1, mk(1, 32'h321, 2, 1, 4, 2)); step();
        csr_raddr_i = 32'h320;
        drive(0, '0);
        alu(0, 0, 0);
        rst_n = 1'b0;
        step();
        chk("mrst_reg_we", reg_we_o, 0);
        chk("mrst_reg_waddr", reg_waddr_o, 0);
        chk("mrst_reg_wdata", reg_wdata_o, 0);
        chk("mrst_csr_we", csr_we_o, 0);
        chk("mrst_csr_waddr", csr_waddr_o, 0);
        chk("mrst_csr_wdata", csr_wdata_o, 0);
        chk("mrst_ready", csr_ready_o, 1);
        chk("mrst_busy", csr_busy_o, 0);
        chk("mrst_hit", csr_raw_hit_o, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mrst_no_stale_csr", csr_we_o, 0);
            chk("mrst_no_stale_reg", reg_we_o, 0);
        end

        // Random traffic; a refused push is held until accepted.
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if (!csr_valid_i || m_pushed) begin
                r = mk($urandom_range(0, 1), 32'h300 + $urandom_range(0, 3), $urandom,
                       $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom);
                drive($urandom_range(0, 9) < 6, r);
            end
            alu($urandom_range(0, 9) < 4, 5'($urandom_range(0, 3)), $urandom);
            csr_raddr_i = 32'h300 + $urandom_range(0, 3);
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
